// File: rtl/rv64g_pkg.sv
// Shared RV64G front-end types: decoded instruction, fetch FIFO entry and
// the issue sequencer state.
package rv64g_pkg;

  localparam int unsigned XLEN = 64;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [4:0] {
    INVALID, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND
  } funct_t;

  typedef struct packed {
    funct_t            funct;
    logic [2:0]        funct3;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [XLEN-1:0]   imm;
  } decoded_instr_t;

  typedef struct packed {
    logic [31:0]       code;
    logic [XLEN-1:0]   pc;
  } fetch_entry_t;

  typedef enum logic {RUN, TRAP} issue_state_t;

  function automatic logic [XLEN-1:0] sext12(input logic [11:0] v);
    return {{(XLEN-12){v[11]}}, v};
  endfunction

endpackage

// File: rtl/instruction_decoder.sv
// Combinational RV64I base-integer decoder; anything it does not recognise
// is reported as INVALID with all fields zero.
module instruction_decoder
  import rv64g_pkg::*;
(
  input  logic [31:0]    code,
  output decoded_instr_t cmd
);

  logic [6:0]      opcode_s;
  logic [2:0]      f3_s;
  logic [6:0]      f7_s;
  funct_t          funct_s;
  logic            use_rd_s;
  logic            use_rs1_s;
  logic            use_rs2_s;
  logic [XLEN-1:0] imm_s;

  assign opcode_s = code[6:0];
  assign f3_s     = code[14:12];
  assign f7_s     = code[31:25];

  // Classify the word and select its operand usage and immediate format.
  always_comb begin
    funct_s   = INVALID;
    use_rd_s  = 1'b0;
    use_rs1_s = 1'b0;
    use_rs2_s = 1'b0;
    imm_s     = '0;
    case (opcode_s)
      OPC_LUI, OPC_AUIPC: begin
        funct_s  = (opcode_s == OPC_LUI) ? LUI : AUIPC;
        use_rd_s = 1'b1;
        imm_s    = {{(XLEN-32){code[31]}}, code[31:12], 12'h000};
      end
      OPC_JAL: begin
        funct_s  = JAL;
        use_rd_s = 1'b1;
        imm_s    = {{(XLEN-21){code[31]}}, code[31], code[19:12], code[20],
                    code[30:21], 1'b0};
      end
      OPC_JALR: begin
        funct_s   = (f3_s == 3'b000) ? JALR : INVALID;
        use_rd_s  = 1'b1;
        use_rs1_s = 1'b1;
        imm_s     = sext12(code[31:20]);
      end
      OPC_BRANCH: begin
        funct_s   = ((f3_s == 3'b010) || (f3_s == 3'b011)) ? INVALID : BRANCH;
        use_rs1_s = 1'b1;
        use_rs2_s = 1'b1;
        imm_s     = {{(XLEN-13){code[31]}}, code[31], code[7], code[30:25],
                     code[11:8], 1'b0};
      end
      OPC_LOAD: begin
        funct_s   = (f3_s == 3'b111) ? INVALID : LOAD;
        use_rd_s  = 1'b1;
        use_rs1_s = 1'b1;
        imm_s     = sext12(code[31:20]);
      end
      OPC_STORE: begin
        funct_s   = f3_s[2] ? INVALID : STORE;
        use_rs1_s = 1'b1;
        use_rs2_s = 1'b1;
        imm_s     = sext12({code[31:25], code[11:7]});
      end
      OPC_OPIMM: begin
        use_rd_s  = 1'b1;
        use_rs1_s = 1'b1;
        imm_s     = sext12(code[31:20]);
        case (f3_s)
          3'b000:  funct_s = ADDI;
          3'b010:  funct_s = SLTI;
          3'b011:  funct_s = SLTIU;
          3'b100:  funct_s = XORI;
          3'b110:  funct_s = ORI;
          3'b111:  funct_s = ANDI;
          3'b001:  funct_s = (code[31:26] == 6'b000000) ? SLLI : INVALID;
          3'b101:  funct_s = (code[31:26] == 6'b000000) ? SRLI :
                             (code[31:26] == 6'b010000) ? SRAI : INVALID;
          default: funct_s = INVALID;
        endcase
      end
      OPC_OP: begin
        use_rd_s  = 1'b1;
        use_rs1_s = 1'b1;
        use_rs2_s = 1'b1;
        case ({f7_s, f3_s})
          10'b0000000_000: funct_s = ADD;
          10'b0100000_000: funct_s = SUB;
          10'b0000000_001: funct_s = SLL;
          10'b0000000_010: funct_s = SLT;
          10'b0000000_011: funct_s = SLTU;
          10'b0000000_100: funct_s = XOR;
          10'b0000000_101: funct_s = SRL;
          10'b0100000_101: funct_s = SRA;
          10'b0000000_110: funct_s = OR;
          10'b0000000_111: funct_s = AND;
          default:         funct_s = INVALID;
        endcase
      end
      default: funct_s = INVALID;
    endcase
  end

  // Unused register fields are forced to x0 so they can never cause a stall.
  always_comb begin
    cmd = '0;
    if (funct_s != INVALID) begin
      cmd.funct  = funct_s;
      cmd.funct3 = f3_s;
      cmd.rd     = use_rd_s  ? code[11:7]  : 5'd0;
      cmd.rs1    = use_rs1_s ? code[19:15] : 5'd0;
      cmd.rs2    = use_rs2_s ? code[24:20] : 5'd0;
      cmd.imm    = imm_s;
    end else begin
      cmd.funct  = INVALID;
    end
  end

endmodule

// File: rtl/decode_issue_ctrl.sv
// Fetch-to-execute sequencer: small fetch FIFO, head decode, busy-bit
// scoreboard and a single valid/ready issue register with illegal-word trap.
module decode_issue_ctrl
  import rv64g_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              fetch_valid_i,
  output logic              fetch_ready_o,
  input  logic [31:0]       fetch_code_i,
  input  logic [XLEN-1:0]   fetch_pc_i,
  output logic              issue_valid_o,
  input  logic              issue_ready_i,
  output decoded_instr_t    issue_cmd_o,
  output logic [XLEN-1:0]   issue_pc_o,
  input  logic              wb_valid_i,
  input  logic [4:0]        wb_rd_i,
  output logic              illegal_o,
  output logic [XLEN-1:0]   illegal_pc_o,
  output logic [31:0]       busy_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     fifo_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  issue_state_t     state_r;
  logic             issue_valid_r;
  decoded_instr_t   issue_cmd_r;
  logic [XLEN-1:0]  issue_pc_r;
  logic             illegal_r;
  logic [XLEN-1:0]  illegal_pc_r;
  logic [31:0]      busy_r;

  fetch_entry_t     head_s;
  decoded_instr_t   head_cmd_s;
  logic             hazard_s;
  logic             active_s;
  logic             load_s;
  logic             illegal_s;
  logic             push_s;
  logic             pop_s;
  logic [31:0]      clr_mask_s;
  logic [31:0]      set_mask_s;
  logic [31:0]      busy_next_s;
  logic [CNT_W-1:0] count_next_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign head_s = fifo_r[rd_ptr_r];

  instruction_decoder u_decoder (
    .code (head_s.code),
    .cmd  (head_cmd_s)
  );

  // RAW on either source or WAW on the destination; x0 never conflicts.
  assign hazard_s = ((head_cmd_s.rs1 != 5'd0) && busy_r[head_cmd_s.rs1])
                 || ((head_cmd_s.rs2 != 5'd0) && busy_r[head_cmd_s.rs2])
                 || ((head_cmd_s.rd  != 5'd0) && busy_r[head_cmd_s.rd]);

  assign active_s  = (count_r != '0) && (state_r == RUN);
  assign illegal_s = active_s && (head_cmd_s.funct == INVALID);
  assign load_s    = active_s && (head_cmd_s.funct != INVALID) && !hazard_s
                  && (!issue_valid_r || issue_ready_i);
  assign pop_s     = load_s || illegal_s;

  assign fetch_ready_o = rst_ni && (count_r < CNT_W'(DEPTH)) && (state_r == RUN);
  assign push_s        = fetch_valid_i && fetch_ready_o;

  // Release is applied before claim so a same-cycle set of one bit wins.
  assign clr_mask_s  = {31'd0, wb_valid_i} << wb_rd_i;
  assign set_mask_s  = {31'd0, load_s} << head_cmd_s.rd;
  assign busy_next_s = ((busy_r & ~clr_mask_s) | set_mask_s) & ~32'd1;

  // FIFO occupancy after this cycle's push and pop.
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Control state, issue register, scoreboard and illegal reporting.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_r      <= '0;
      rd_ptr_r      <= '0;
      count_r       <= '0;
      state_r       <= RUN;
      issue_valid_r <= 1'b0;
      issue_cmd_r   <= '0;
      issue_pc_r    <= '0;
      illegal_r     <= 1'b0;
      illegal_pc_r  <= '0;
      busy_r        <= '0;
    end else if (flush_i) begin
      wr_ptr_r      <= '0;
      rd_ptr_r      <= '0;
      count_r       <= '0;
      state_r       <= RUN;
      issue_valid_r <= 1'b0;
      illegal_r     <= 1'b0;
      busy_r        <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r   <= count_next_s;
      busy_r    <= busy_next_s;
      illegal_r <= illegal_s;
      if (illegal_s) begin
        illegal_pc_r <= head_s.pc;
      end
      if (load_s) begin
        issue_valid_r <= 1'b1;
        issue_cmd_r   <= head_cmd_s;
        issue_pc_r    <= head_s.pc;
      end else if (issue_ready_i) begin
        issue_valid_r <= 1'b0;
      end
      case (state_r)
        RUN:     state_r <= illegal_s ? TRAP : RUN;
        TRAP:    state_r <= TRAP;
        default: state_r <= RUN;
      endcase
    end
  end

  // Entry storage is qualified by the pointers, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      fifo_r[wr_ptr_r] <= fetch_entry_t'{code: fetch_code_i, pc: fetch_pc_i};
    end
  end

  assign issue_valid_o = issue_valid_r;
  assign issue_cmd_o   = issue_cmd_r;
  assign issue_pc_o    = issue_pc_r;
  assign illegal_o     = illegal_r;
  assign illegal_pc_o  = illegal_pc_r;
  assign busy_o        = busy_r;

endmodule
